// File: rtl/pu_div_iter.sv
// pu_div_iter: iterative restoring divider on the PU bus. It produces a signed or unsigned
// quotient and remainder at BITS_PER_CYCLE quotient bits per cycle and flags invalid results.
module pu_div_iter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 4,
  parameter int INVALID        = 0,
  parameter int SIGNED         = 1,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_wr_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  input  logic                  signal_oe_sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  busy
);
  localparam int W     = DATA_WIDTH;
  localparam int STEPS = W / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [W-1:0]   num_q, num_d, den_q, den_d;
  logic           num_inv_q, num_inv_d, den_inv_q, den_inv_d;
  logic [W-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic           neg_q_q, neg_q_d, neg_r_q, neg_r_d, inv_q, inv_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   q_res_q, q_res_d, r_res_q, r_res_d;
  logic           inv_res_q, inv_res_d;
  logic           sn, sd, min_ovf;
  logic [W-1:0]   mag_n, mag_d, q, r;
  logic [W:0]     rr, diff;
  logic           unused_attr;
  assign unused_attr = ^attr_in;
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    num_d     = num_q;
    num_inv_d = num_inv_q;
    den_d     = den_q;
    den_inv_d = den_inv_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    q_res_d   = q_res_q;
    r_res_d   = r_res_q;
    inv_res_d = inv_res_q;
    sn        = (SIGNED != 0) && num_q[W-1];
    sd        = (SIGNED != 0) && den_q[W-1];
    mag_n     = sn ? -num_q : num_q;
    mag_d     = sd ? -den_q : den_q;
    min_ovf   = (SIGNED != 0) && (num_q == {1'b1, {(W-1){1'b0}}}) && (&den_q);
    q         = quo_q;
    r         = rem_q;
    rr        = '0;
    diff      = '0;
    // a borrow out of the trial subtraction means the divisor did not fit: restore
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rr   = {r, q[W-1]};
      diff = rr - {1'b0, dvs_q};
      r    = diff[W] ? rr[W-1:0] : diff[W-1:0];
      q    = {q[W-2:0], ~diff[W]};
    end
    if (signal_wr && !signal_wr_sel) begin
      num_d     = data_in;
      num_inv_d = attr_in[INVALID];
    end
    if (signal_wr && signal_wr_sel) begin
      den_d     = data_in;
      den_inv_d = attr_in[INVALID];
      start_d   = 1'b1;
    end
    unique case (state_q)
      LOAD: begin
        quo_d   = mag_n;
        rem_d   = '0;
        dvs_d   = mag_d;
        neg_q_d = sn ^ sd;
        neg_r_d = sn;
        inv_d   = num_inv_q | den_inv_q;
        cnt_d   = '0;
        state_d = CALC;
        if (den_q == '0 || min_ovf) begin
          quo_d   = den_q == '0 ? '1 : num_q;
          rem_d   = den_q == '0 ? num_q : '0;
          neg_q_d = 1'b0;
          neg_r_d = 1'b0;
          inv_d   = 1'b1;
          state_d = DONE;
        end
      end
      CALC: begin
        quo_d   = q;
        rem_d   = r;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(STEPS - 1) ? DONE : CALC;
      end
      DONE: begin
        q_res_d   = neg_q_q ? -quo_q : quo_q;
        r_res_d   = neg_r_q ? -rem_q : rem_q;
        inv_res_d = inv_q;
        state_d   = IDLE;
      end
      default: ;
    endcase
    // a new denominator kills whatever is running; the following edge enters LOAD
    if (signal_wr && signal_wr_sel) state_d = IDLE;
    else if (start_q) state_d = LOAD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      num_q     <= '0;
      num_inv_q <= 1'b0;
      den_q     <= '0;
      den_inv_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      inv_q     <= 1'b0;
      cnt_q     <= '0;
      q_res_q   <= '0;
      r_res_q   <= '0;
      inv_res_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      num_q     <= num_d;
      num_inv_q <= num_inv_d;
      den_q     <= den_d;
      den_inv_q <= den_inv_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
      q_res_q   <= q_res_d;
      r_res_q   <= r_res_d;
      inv_res_q <= inv_res_d;
    end
  end
  always_comb begin
    busy              = start_q || state_q == LOAD || state_q == CALC;
    data_out          = signal_oe ? (signal_oe_sel ? q_res_q : r_res_q) : '0;
    attr_out          = '0;
    attr_out[INVALID] = signal_oe & inv_res_q;
  end
endmodule

// File: tb/tb_pu_div_iter.sv
// tb_pu_div_iter: directed checks of four divider variants driven from one shared bus:
// unsigned radix-2 and signed with 1, 2 and 4 quotient bits per cycle.
module tb_pu_div_iter;
  logic        clk = 0, rst = 0, wr = 0, wr_sel = 0, oe = 1, oe_sel = 0;
  logic [31:0] din = 0;
  logic [3:0]  ain = 0;
  logic [31:0] dout [4];
  logic [3:0]  aout [4];
  logic        bsy [4];
  int          checks = 0, errors = 0;
  int          bpc [4] = '{1, 1, 2, 4};
  bit          sgn [4] = '{0, 1, 1, 1};
  logic [31:0] eq [4], er [4], pq [4];
  bit          ei [4];
  always #5 clk = ~clk;
  pu_div_iter #(.SIGNED(0), .BITS_PER_CYCLE(1)) u_u1 (.clk(clk), .rst(rst), .signal_wr(wr),
    .signal_wr_sel(wr_sel), .data_in(din), .attr_in(ain), .signal_oe(oe), .signal_oe_sel(oe_sel),
    .data_out(dout[0]), .attr_out(aout[0]), .busy(bsy[0]));
  pu_div_iter #(.SIGNED(1), .BITS_PER_CYCLE(1)) u_s1 (.clk(clk), .rst(rst), .signal_wr(wr),
    .signal_wr_sel(wr_sel), .data_in(din), .attr_in(ain), .signal_oe(oe), .signal_oe_sel(oe_sel),
    .data_out(dout[1]), .attr_out(aout[1]), .busy(bsy[1]));
  pu_div_iter #(.SIGNED(1), .BITS_PER_CYCLE(2)) u_s2 (.clk(clk), .rst(rst), .signal_wr(wr),
    .signal_wr_sel(wr_sel), .data_in(din), .attr_in(ain), .signal_oe(oe), .signal_oe_sel(oe_sel),
    .data_out(dout[2]), .attr_out(aout[2]), .busy(bsy[2]));
  pu_div_iter #(.SIGNED(1), .BITS_PER_CYCLE(4)) u_s4 (.clk(clk), .rst(rst), .signal_wr(wr),
    .signal_wr_sel(wr_sel), .data_in(din), .attr_in(ain), .signal_oe(oe), .signal_oe_sel(oe_sel),
    .data_out(dout[3]), .attr_out(aout[3]), .busy(bsy[3]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic set_exp(input int d, input logic [31:0] q, input logic [31:0] r, input bit i);
    eq[d] = q;
    er[d] = r;
    ei[d] = i;
  endtask
  task automatic set_all(input logic [31:0] q, input logic [31:0] r, input bit i);
    for (int d = 0; d < 4; d++) set_exp(d, q, r, i);
  endtask
  task automatic chk_idle(input string tag);
    oe_sel = 1;
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("%s q%0d", tag, d), dout[d], 32'h0);
    oe_sel = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s r%0d", tag, d), dout[d], 32'h0);
      chk($sformatf("%s a%0d", tag, d), {28'h0, aout[d]}, 32'h0);
      chk($sformatf("%s busy%0d", tag, d), {31'h0, bsy[d]}, 32'h0);
    end
  endtask
  // called at a negedge; sp: special for every variant, sps: special for signed variants only
  task automatic op(input bit wn, input logic [31:0] n, input bit ni, input logic [31:0] dv,
                    input bit di, input bit sp, input bit sps);
    int lat [4];
    int bc [4];
    logic [31:0] q [4];
    if (wn) begin
      wr = 1; wr_sel = 0; din = n; ain = {3'b0, ni};
      @(negedge clk);
    end
    wr = 1; wr_sel = 1; din = dv; ain = {3'b0, di};
    @(negedge clk);
    wr = 0; wr_sel = 0; ain = 0;
    for (int d = 0; d < 4; d++) begin
      bc[d] = 0;
      lat[d] = (sp || (sps && sgn[d])) ? 3 : 32 / bpc[d] + 3;
    end
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) @(negedge clk);
      oe_sel = 1;
      #1;
      for (int d = 0; d < 4; d++) q[d] = dout[d];
      oe_sel = 0;
      #1;
      for (int d = 0; d < 4; d++) begin
        bc[d] += int'(bsy[d]);
        if (k == lat[d] - 1) chk($sformatf("stale q%0d", d), q[d], pq[d]);
        if (k == lat[d]) begin
          chk($sformatf("quot%0d", d), q[d], eq[d]);
          chk($sformatf("rem%0d", d), dout[d], er[d]);
          chk($sformatf("attr%0d", d), {28'h0, aout[d]}, {31'h0, ei[d]});
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("busy cycles%0d", d), bc[d], lat[d] - 1);
      pq[d] = eq[d];
    end
  endtask
  initial begin
    for (int d = 0; d < 4; d++) pq[d] = 0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1;
    @(negedge clk);
    set_all(32'd14, 32'd2, 0);
    op(1, 32'd100, 0, 32'd7, 0, 0, 0);
    oe = 0;
    oe_sel = 1;
    #1;
    chk("oe low data", dout[1], 32'h0);
    chk("oe low attr", {28'h0, aout[1]}, 32'h0);
    oe = 1;
    @(negedge clk);
    set_all(32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    set_exp(0, 32'h7FFFFFFC, 32'd1, 0);
    op(1, 32'hFFFFFFF9, 0, 32'd2, 0, 0, 0);
    set_all(32'hFFFFFFFD, 32'd1, 0);
    set_exp(0, 32'd0, 32'd7, 0);
    op(1, 32'd7, 0, 32'hFFFFFFFE, 0, 0, 0);
    set_all(32'hFFFFFFFF, 32'd55, 1);
    op(1, 32'd55, 0, 32'd0, 0, 1, 0);
    set_all(32'h80000000, 32'd0, 1);
    set_exp(0, 32'd0, 32'h80000000, 0);
    op(1, 32'h80000000, 0, 32'hFFFFFFFF, 0, 0, 1);
    set_all(32'd14, 32'd2, 1);
    op(1, 32'd100, 1, 32'd7, 0, 0, 0);
    set_all(32'hFFFFFFF2, 32'hFFFFFFFE, 1);
    set_exp(0, 32'h24924916, 32'd2, 1);
    op(1, 32'hFFFFFF9C, 0, 32'd7, 1, 0, 0);
    wr = 1; wr_sel = 0; din = 32'd1000;
    @(negedge clk);
    wr_sel = 1; din = 32'd3;
    @(negedge clk);
    wr = 0; wr_sel = 0;
    repeat (6) @(negedge clk);
    set_all(32'd100, 32'd0, 0);
    op(0, 32'd0, 0, 32'd10, 0, 0, 0);
    wr = 1; wr_sel = 0; din = 32'd100;
    @(negedge clk);
    wr_sel = 1; din = 32'd7;
    @(negedge clk);
    wr = 0; wr_sel = 0;
    repeat (5) @(negedge clk);
    rst = 0;
    chk_idle("mid reset");
    @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    chk_idle("after reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
